// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared FSM state encoding, opcode constants and writeback-select
// encodings for the multi-cycle control FSM.
`default_nettype none

package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  // Opcodes that write back without carrying an ALU class flag.
  function automatic logic is_wb_opcode(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL);
  endfunction

  function automatic logic [1:0] wb_select(input logic load, input logic [6:0] op);
    if (load)                return WB_LOAD;
    else if (op == OP_JAL)   return WB_PC4;
    else if (op == OP_LUI)   return WB_IMM;
    else                     return WB_ALU;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts cycles a memory request waits without ready and
// flags the cycle in which the LIMIT-th waiting cycle occurs.
`default_nettype none

`ifdef CTRL_MEM_TIMEOUT_EN
module ctrl_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic pending,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (pending) begin
      count <= count + 8'd1;
    end
  end

  // count holds the waiting cycles already elapsed, so LIMIT-1 marks the LIMIT-th.
  assign expired = pending && (count == 8'(LIMIT - 1));

endmodule
`endif

`default_nettype wire

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer.
// Define CTRL_MEM_TIMEOUT_EN to bound memory waits with a TIMEOUT_CYCLES trap.
`default_nettype none

module control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        is_alu_op,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        trap_cause,
  output logic [31:0] instret
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
    $error("control_fsm: TIMEOUT_CYCLES must be within 2..255");
  end

  state_t      state;
  state_t      state_next;
  logic [31:0] instret_count;
  logic        timeout;

`ifdef CTRL_MEM_TIMEOUT_EN
  logic wait_pending;
  logic wait_clear;
  logic trap_cause_q;

  assign wait_pending = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);
  assign wait_clear   = (state_next != state) && ((state_next == FETCH) || (state_next == MEM));

  ctrl_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .pending (wait_pending),
    .expired (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_cause_q <= 1'b0;
    end else if ((state != TRAP) && (state_next == TRAP)) begin
      trap_cause_q <= timeout;
    end
  end

  assign trap_cause = trap_cause_q & ~rst;
`else
  assign timeout    = 1'b0;
  assign trap_cause = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_count <= 32'd0;
    end else if (pc_we) begin
      instret_count <= instret_count + 32'd1;
    end
  end

  // Reset masks the registered view so it reads as cleared during the reset cycle.
  assign instret = rst ? 32'd0 : instret_count;
  assign halted  = (state == TRAP) && !rst;

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;

    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          state_next = TRAP;
        end
      end
      DECODE: begin
        state_next = EXEC;
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_next = MEM;
        end else if (is_branch) begin
          pc_we      = 1'b1;
          pc_sel     = branch_taken;
          state_next = FETCH;
        end else if (is_alu_op || is_wb_opcode(opcode)) begin
          state_next = WB;
        end else begin
          state_next = TRAP;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we      = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end else if (timeout) begin
          state_next = TRAP;
        end
      end
      WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = (opcode == OP_JAL);
        wb_sel     = wb_select(is_load, opcode);
        state_next = FETCH;
      end
      TRAP: begin
        state_next = TRAP;
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    // Reset abandons any access in flight and wins over every transition.
    if (rst) begin
      state_next = FETCH;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      reg_we     = 1'b0;
      wb_sel     = WB_ALU;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// tb_control_fsm: per-instruction timeline model with random classes, waits
// and spurious ready pulses, plus directed reset/trap/timeout scenarios.
`default_nettype none

module tb_control_fsm;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        is_alu_op, is_load, is_store, is_branch, branch_taken;
  logic        imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we;
  logic [1:0]  wb_sel;
  logic        halted, trap_cause;
  logic [31:0] instret;

  control_fsm #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .is_alu_op(is_alu_op), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .halted(halted), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam int C_ADD = 0, C_IALU = 1, C_LUI = 2, C_AUIPC = 3, C_JAL = 4,
                 C_LOAD = 5, C_STORE = 6, C_BRANCH = 7, C_ILLEGAL = 8;

  // One expected cycle: outputs required plus the ready values the bench drives.
  typedef struct {
    bit       imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we, halted, tcause;
    bit [1:0] wb_sel;
    bit       imem_rdy, dmem_rdy;
  } cyc_t;

  cyc_t        plan[$];
  int          total = 0;
  int          bad = 0;
  int unsigned model_instret = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cyc_t idle_cycle();
    cyc_t c = '{default: 0};
    c.imem_rdy = 1'($urandom % 2);
    c.dmem_rdy = 1'($urandom % 2);
    return c;
  endfunction

  task automatic set_instr(input int cls, input bit taken);
    is_alu_op = 0; is_load = 0; is_store = 0; is_branch = 0;
    branch_taken = taken;
    case (cls)
      C_ADD:    begin opcode = OP_R;      is_alu_op = 1; end
      C_IALU:   begin opcode = OP_I_ALU;  is_alu_op = 1; end
      C_LUI:      opcode = OP_LUI;
      C_AUIPC:    opcode = OP_AUIPC;
      C_JAL:      opcode = OP_JAL;
      C_LOAD:   begin opcode = OP_LOAD;   is_load = 1; end
      C_STORE:  begin opcode = OP_STORE;  is_store = 1; end
      C_BRANCH: begin opcode = OP_BRANCH; is_branch = 1; end
      default:    opcode = 7'h7F;
    endcase
  endtask

  task automatic plan_fetch(input int iw);
    cyc_t c;
    for (int i = 0; i < iw; i++) begin
      c = idle_cycle(); c.imem_req = 1; c.imem_rdy = 0; plan.push_back(c);
    end
    c = idle_cycle(); c.imem_req = 1; c.ir_we = 1; c.imem_rdy = 1; plan.push_back(c);
  endtask

  task automatic plan_trap(input int n, input bit cause);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = idle_cycle(); c.halted = 1; c.tcause = cause; plan.push_back(c);
    end
  endtask

  // Timeline of one instruction: fetch wait, decode, exec, memory wait, writeback.
  task automatic plan_instr(input int cls, input int iw, input int dw, input bit taken);
    cyc_t c;
    plan_fetch(iw);
    c = idle_cycle(); plan.push_back(c);
    c = idle_cycle();
    if (cls == C_BRANCH) begin c.pc_we = 1; c.pc_sel = taken; end
    plan.push_back(c);
    if (cls == C_LOAD || cls == C_STORE) begin
      for (int i = 0; i <= dw; i++) begin
        c = idle_cycle();
        c.dmem_req = 1; c.dmem_we = (cls == C_STORE);
        c.dmem_rdy = (i == dw);
        c.pc_we    = (i == dw) && (cls == C_STORE);
        plan.push_back(c);
      end
    end
    if (cls <= C_LOAD) begin
      c = idle_cycle(); c.reg_we = 1; c.pc_we = 1; c.pc_sel = (cls == C_JAL);
      c.wb_sel = (cls == C_LOAD) ? 2'd1 : (cls == C_JAL) ? 2'd2 : (cls == C_LUI) ? 2'd3 : 2'd0;
      plan.push_back(c);
    end
    if (cls == C_ILLEGAL) plan_trap(20, 1'b0);
  endtask

  // Entered and left at a negedge; n < 0 runs the whole plan.
  task automatic run_plan(input int n);
    cyc_t c;
    int   k = 0;
    while (plan.size() > 0 && (n < 0 || k < n)) begin
      c = plan.pop_front();
      imem_ready = c.imem_rdy;
      dmem_ready = c.dmem_rdy;
      #1;
      check("imem_req", imem_req, c.imem_req);
      check("ir_we", ir_we, c.ir_we);
      check("dmem_req", dmem_req, c.dmem_req);
      if (c.dmem_req) check("dmem_we", dmem_we, c.dmem_we);
      check("pc_we", pc_we, c.pc_we);
      if (c.pc_we) check("pc_sel", pc_sel, c.pc_sel);
      check("reg_we", reg_we, c.reg_we);
      if (c.reg_we) check("wb_sel", wb_sel, c.wb_sel);
      check("halted", halted, c.halted);
      check("trap_cause", trap_cause, c.tcause);
      check("instret", instret, model_instret);
      if (c.pc_we) model_instret++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input int cls, input int iw, input int dw, input bit taken);
    set_instr(cls, taken);
    plan_instr(cls, iw, dw, taken);
    run_plan(-1);
  endtask

  task automatic do_reset();
    rst = 1; imem_ready = 0; dmem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_imem_req", imem_req, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_instret", instret, 0);
      check("rst_halted", halted, 0);
      check("rst_trap_cause", trap_cause, 0);
      @(negedge clk);
    end
    rst = 0;
    model_instret = 0;
  endtask

  initial begin
    rst = 1; imem_ready = 0; dmem_ready = 0;
    set_instr(C_ADD, 0);
    @(negedge clk);
    do_reset();

    do_instr(C_ADD, 0, 0, 0);
    check("add_instret", instret, 1);
    do_instr(C_LOAD, 0, 3, 0);
    do_instr(C_BRANCH, 0, 0, 1);
    do_instr(C_BRANCH, 0, 0, 0);
    check("branch_instret", instret, 4);

    for (int i = 0; i < 60; i++) begin
      do_instr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom % 2));
    end

    // Store interrupted by reset while waiting in MEM.
    set_instr(C_STORE, 0);
    plan_instr(C_STORE, 0, 4, 0);
    run_plan(4);
    plan.delete();
    rst = 1; dmem_ready = 0; imem_ready = 0;
    #1;
    check("mid_rst_dmem_req", dmem_req, 0);
    check("mid_rst_imem_req", imem_req, 0);
    @(negedge clk);
    rst = 0;
    model_instret = 0;
    do_instr(C_ADD, 1, 0, 0);

    // Illegal opcode traps and stays halted until reset.
    do_instr(C_ILLEGAL, 0, 0, 0);
    check("trap_instret", instret, model_instret);
    do_reset();
    do_instr(C_IALU, 0, 0, 0);

`ifdef CTRL_MEM_TIMEOUT_EN
    // Fetch never answered: trap after the 16th request cycle.
    set_instr(C_ADD, 0);
    begin
      cyc_t c;
      for (int i = 0; i < 16; i++) begin
        c = idle_cycle(); c.imem_req = 1; c.imem_rdy = 0; plan.push_back(c);
      end
    end
    plan_trap(5, 1'b1);
    run_plan(-1);
    do_reset();
    // Ready arriving on the limit cycle wins.
    do_instr(C_ADD, 15, 0, 0);
    do_instr(C_LOAD, 0, 15, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
